// File: rtl/descriptor_fetch.sv
// descriptor_fetch: walks a chain of 4-word descriptors held in the
// single-port descriptor RAM. Each owned descriptor is handed to the DMA
// datapath, its completion status is written back into the ctrl word and
// the next pointer is followed until LAST, an unowned descriptor, an error
// status or the loop guard ends the chain.
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | waiting for start
// FETCH    | four pipelined reads of B+0..B+3, one extra capture cycle
// CHECK    | decide: clean end (OWN=0), skip (len=0) or issue
// ISSUE    | command presented on cmd port until handshake
// WAIT_CPL | waiting for the DMA completion pulse
// WB       | status writeback into B+2, bytes 3..1 only
// NEXT     | count descriptor, check LAST and loop guard, follow pointer
// FINISH   | one-cycle done pulse, busy low
module descriptor_fetch #(
    parameter int ADDR_W   = 11,
    parameter int MAX_DESC = 2048
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] mem_address,
    output logic [3:0]        mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    output logic              mem_clken,
    input  logic [31:0]       mem_readdata,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [31:0]       cmd_src,
    output logic [31:0]       cmd_dst,
    output logic [15:0]       cmd_len,
    input  logic              cpl_valid,
    input  logic [7:0]        cpl_status
);

    localparam int CNT_W = $clog2(MAX_DESC + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CHECK,
        S_ISSUE,
        S_WAIT_CPL,
        S_WB,
        S_NEXT,
        S_FINISH
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic [1:0]         rst_sync;
    logic               rst_int_n;

    logic [ADDR_W-1:0]  base;
    logic [2:0]         fcnt;
    logic [31:0]        src;
    logic [31:0]        dst;
    logic               own;
    logic               last;
    logic [5:0]         ctrl_hi;
    logic [15:0]        len;
    logic [ADDR_W-1:0]  next_ptr;
    logic [7:0]         status;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   count_inc;
    logic               err;
    logic               status_bad;
    logic               limit_hit;

    assign count_inc  = count + CNT_W'(1);
    assign status_bad = (status != 8'h00) && (status != 8'hFF);
    assign limit_hit  = (count_inc == CNT_W'(MAX_DESC));

    // Reset asserts immediately, releases two clocks after reset_n rises.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync[1];

    // State register.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and bus/command outputs, all decoded from state so a
    // reset forces the bus idle and the command port low in the same instant.
    always_comb begin
        state_nxt      = state;
        busy           = 1'b0;
        done           = 1'b0;
        mem_address    = '0;
        mem_byteenable = 4'b0000;
        mem_chipselect = 1'b0;
        mem_write      = 1'b0;
        mem_writedata  = 32'h0000_0000;
        cmd_valid      = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                busy = 1'b1;
                if (!fcnt[2]) begin
                    mem_chipselect = 1'b1;
                    mem_byteenable = 4'b1111;
                    mem_address    = base + ADDR_W'(fcnt[1:0]);
                end
                if (fcnt == 3'd4) begin
                    state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                busy = 1'b1;
                if (!own) begin
                    state_nxt = S_FINISH;
                end else if (len == 16'h0000) begin
                    state_nxt = S_WB;
                end else begin
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                busy      = 1'b1;
                cmd_valid = 1'b1;
                if (cmd_ready) begin
                    state_nxt = S_WAIT_CPL;
                end
            end
            S_WAIT_CPL: begin
                busy = 1'b1;
                if (cpl_valid) begin
                    state_nxt = S_WB;
                end
            end
            S_WB: begin
                busy           = 1'b1;
                mem_chipselect = 1'b1;
                mem_write      = 1'b1;
                mem_byteenable = 4'b1110;
                mem_address    = base + ADDR_W'(2);
                // OWN cleared, LAST and len[15:8] rewritten unchanged, byte 0 masked.
                mem_writedata  = {1'b0, last, ctrl_hi, status, len[15:8], 8'h00};
                if (status_bad) begin
                    state_nxt = S_FINISH;
                end else begin
                    state_nxt = S_NEXT;
                end
            end
            S_NEXT: begin
                busy = 1'b1;
                if (last || limit_hit) begin
                    state_nxt = S_FINISH;
                end else begin
                    state_nxt = S_FETCH;
                end
            end
            S_FINISH: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign mem_clken = 1'b1;
    assign error     = err;
    assign cmd_src   = src;
    assign cmd_dst   = dst;
    assign cmd_len   = len;

    // Descriptor capture, status latch, chain bookkeeping and sticky error.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            base     <= '0;
            fcnt     <= 3'd0;
            src      <= 32'h0000_0000;
            dst      <= 32'h0000_0000;
            own      <= 1'b0;
            last     <= 1'b0;
            ctrl_hi  <= 6'd0;
            len      <= 16'h0000;
            next_ptr <= '0;
            status   <= 8'h00;
            count    <= '0;
            err      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        base  <= start_addr;
                        err   <= 1'b0;
                        count <= '0;
                        fcnt  <= 3'd0;
                    end
                end
                S_FETCH: begin
                    fcnt <= fcnt + 3'd1;
                    // Read data lags the presented address by one cycle.
                    case (fcnt)
                        3'd1: src <= mem_readdata;
                        3'd2: dst <= mem_readdata;
                        3'd3: begin
                            own     <= mem_readdata[31];
                            last    <= mem_readdata[30];
                            ctrl_hi <= mem_readdata[29:24];
                            len     <= mem_readdata[15:0];
                        end
                        3'd4: next_ptr <= mem_readdata[ADDR_W-1:0];
                        default: begin
                        end
                    endcase
                end
                S_CHECK: begin
                    if (own && (len == 16'h0000)) begin
                        status <= 8'hFF;
                    end
                end
                S_WAIT_CPL: begin
                    if (cpl_valid) begin
                        status <= cpl_status;
                    end
                end
                S_WB: begin
                    if (status_bad) begin
                        err <= 1'b1;
                    end
                end
                S_NEXT: begin
                    count <= count_inc;
                    if (!last) begin
                        if (limit_hit) begin
                            err <= 1'b1;
                        end else begin
                            base <= next_ptr;
                            fcnt <= 3'd0;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
